// File: rtl/rs_alu_scheduler.sv
`default_nettype none
// ============================================================================
// rs_alu_scheduler : ALU reservation station, dual-CDB wakeup, lowest-index issue.
// Revision 1.0
// ============================================================================
module rs_alu_scheduler #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [OP_W-1:0]  dispatch_op,
  input  logic [XLEN-1:0]  dispatch_pc,
  input  logic [XLEN-1:0]  dispatch_imm,
  input  logic [ROB_W-1:0] dispatch_rd_rename,
  input  logic             dispatch_rs1_ready,
  input  logic             dispatch_rs2_ready,
  input  logic [XLEN-1:0]  dispatch_rs1_value,
  input  logic [XLEN-1:0]  dispatch_rs2_value,
  input  logic [ROB_W-1:0] dispatch_rs1_tag,
  input  logic [ROB_W-1:0] dispatch_rs2_tag,
  output logic             rs_full,
  input  logic             cdb0_valid,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb0_tag,
  input  logic [ROB_W-1:0] cdb1_tag,
  input  logic [XLEN-1:0]  cdb0_value,
  input  logic [XLEN-1:0]  cdb1_value,
  output logic             alu_enable,
  output logic [OP_W-1:0]  alu_op,
  output logic [XLEN-1:0]  alu_pc,
  output logic [XLEN-1:0]  alu_imm,
  output logic [XLEN-1:0]  alu_rs1_value,
  output logic [XLEN-1:0]  alu_rs2_value,
  output logic [ROB_W-1:0] alu_rd_rename
);

  localparam int c_IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rs1_rdy;
  logic [DEPTH-1:0] r_rs2_rdy;
  logic [OP_W-1:0]  r_op      [DEPTH];
  logic [XLEN-1:0]  r_pc      [DEPTH];
  logic [XLEN-1:0]  r_imm     [DEPTH];
  logic [ROB_W-1:0] r_rd      [DEPTH];
  logic [ROB_W-1:0] r_rs1_tag [DEPTH];
  logic [ROB_W-1:0] r_rs2_tag [DEPTH];
  logic [XLEN-1:0]  r_rs1_val [DEPTH];
  logic [XLEN-1:0]  r_rs2_val [DEPTH];

  // {ready, value} after snooping both CDBs; cdb0 wins a double match.
  logic [XLEN:0]    w_nxt1 [DEPTH];
  logic [XLEN:0]    w_nxt2 [DEPTH];
  logic [XLEN:0]    w_dsp1;
  logic [XLEN:0]    w_dsp2;
  logic             w_free_found;
  logic             w_iss_found;
  logic [c_IDX_W-1:0] w_free_idx;
  logic [c_IDX_W-1:0] w_iss_idx;

  function automatic logic [XLEN:0] f_capture(input logic rdy_in,
                                              input logic [ROB_W-1:0] tag,
                                              input logic [XLEN-1:0] val);
    if (rdy_in) return {1'b1, val};
    if (cdb0_valid && (cdb0_tag == tag)) return {1'b1, cdb0_value};
    if (cdb1_valid && (cdb1_tag == tag)) return {1'b1, cdb1_value};
    return {1'b0, val};
  endfunction

  assign rs_full = &r_valid;
  assign w_dsp1  = f_capture(dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_value);
  assign w_dsp2  = f_capture(dispatch_rs2_ready, dispatch_rs2_tag, dispatch_rs2_value);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt1[i] = f_capture(r_rs1_rdy[i], r_rs1_tag[i], r_rs1_val[i]);
      w_nxt2[i] = f_capture(r_rs2_rdy[i], r_rs2_tag[i], r_rs2_val[i]);
    end
  end

  // Descending scan leaves the lowest matching index in each select.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_iss_found  = 1'b0;
    w_iss_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = c_IDX_W'(i);
      end
      if (r_valid[i] && r_rs1_rdy[i] && r_rs2_rdy[i]) begin
        w_iss_found = 1'b1;
        w_iss_idx   = c_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_valid       <= '0;
      alu_enable    <= 1'b0;
      alu_op        <= '0;
      alu_pc        <= '0;
      alu_imm       <= '0;
      alu_rs1_value <= '0;
      alu_rs2_value <= '0;
      alu_rd_rename <= '0;
    end else if (rdy) begin
      alu_enable <= w_iss_found;
      if (w_iss_found) begin
        alu_op               <= r_op[w_iss_idx];
        alu_pc               <= r_pc[w_iss_idx];
        alu_imm              <= r_imm[w_iss_idx];
        alu_rs1_value        <= r_rs1_val[w_iss_idx];
        alu_rs2_value        <= r_rs2_val[w_iss_idx];
        alu_rd_rename        <= r_rd[w_iss_idx];
        r_valid[w_iss_idx]   <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i]) begin
          r_rs1_rdy[i] <= w_nxt1[i][XLEN];
          r_rs1_val[i] <= w_nxt1[i][XLEN-1:0];
          r_rs2_rdy[i] <= w_nxt2[i][XLEN];
          r_rs2_val[i] <= w_nxt2[i][XLEN-1:0];
        end
      end
      // The free slot is invalid pre-edge, so it never collides with issue or wakeup.
      if (dispatch_valid && w_free_found) begin
        r_valid[w_free_idx]   <= 1'b1;
        r_op[w_free_idx]      <= dispatch_op;
        r_pc[w_free_idx]      <= dispatch_pc;
        r_imm[w_free_idx]     <= dispatch_imm;
        r_rd[w_free_idx]      <= dispatch_rd_rename;
        r_rs1_tag[w_free_idx] <= dispatch_rs1_tag;
        r_rs2_tag[w_free_idx] <= dispatch_rs2_tag;
        r_rs1_rdy[w_free_idx] <= w_dsp1[XLEN];
        r_rs1_val[w_free_idx] <= w_dsp1[XLEN-1:0];
        r_rs2_rdy[w_free_idx] <= w_dsp2[XLEN];
        r_rs2_val[w_free_idx] <= w_dsp2[XLEN-1:0];
      end
    end else begin
      alu_enable <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_alu_scheduler.sv
`default_nettype none
// ============================================================================
// tb_rs_alu_scheduler : directed vector table plus hand-written multi-cycle sequences.
// Revision 1.0
// ============================================================================
module tb_rs_alu_scheduler;

  localparam int DEPTH = 8;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst, rdy, flush;
  logic             dispatch_valid;
  logic [OP_W-1:0]  dispatch_op;
  logic [XLEN-1:0]  dispatch_pc, dispatch_imm;
  logic [ROB_W-1:0] dispatch_rd_rename;
  logic             dispatch_rs1_ready, dispatch_rs2_ready;
  logic [XLEN-1:0]  dispatch_rs1_value, dispatch_rs2_value;
  logic [ROB_W-1:0] dispatch_rs1_tag, dispatch_rs2_tag;
  logic             rs_full;
  logic             cdb0_valid, cdb1_valid;
  logic [ROB_W-1:0] cdb0_tag, cdb1_tag;
  logic [XLEN-1:0]  cdb0_value, cdb1_value;
  logic             alu_enable;
  logic [OP_W-1:0]  alu_op;
  logic [XLEN-1:0]  alu_pc, alu_imm, alu_rs1_value, alu_rs2_value;
  logic [ROB_W-1:0] alu_rd_rename;

  int n_checks = 0;
  int n_fail   = 0;

  rs_alu_scheduler #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
    .dispatch_rd_rename(dispatch_rd_rename),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
    .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .rs_full(rs_full),
    .cdb0_valid(cdb0_valid), .cdb1_valid(cdb1_valid),
    .cdb0_tag(cdb0_tag), .cdb1_tag(cdb1_tag),
    .cdb0_value(cdb0_value), .cdb1_value(cdb1_value),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_rs1_value(alu_rs1_value), .alu_rs2_value(alu_rs2_value),
    .alu_rd_rename(alu_rd_rename)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  pc, imm;
    logic [ROB_W-1:0] rd;
    logic             r1; logic [ROB_W-1:0] t1; logic [XLEN-1:0] v1;
    logic             r2; logic [ROB_W-1:0] t2; logic [XLEN-1:0] v2;
    logic             c0v; logic [ROB_W-1:0] c0t; logic [XLEN-1:0] c0d;
    logic             c1v; logic [ROB_W-1:0] c1t; logic [XLEN-1:0] c1d;
    logic             exp_issue;
    logic [XLEN-1:0]  exp_v1, exp_v2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb0_valid     = 1'b0;
    cdb1_valid     = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic dispatch(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rd,
                          input logic r1, input logic [ROB_W-1:0] t1, input logic [XLEN-1:0] v1,
                          input logic r2, input logic [ROB_W-1:0] t2, input logic [XLEN-1:0] v2);
    dispatch_valid     = 1'b1;
    dispatch_op        = op;
    dispatch_pc        = 32'h0000_1000 + {28'd0, rd};
    dispatch_imm       = 32'h0000_0100 + {28'd0, rd};
    dispatch_rd_rename = rd;
    dispatch_rs1_ready = r1; dispatch_rs1_tag = t1; dispatch_rs1_value = v1;
    dispatch_rs2_ready = r2; dispatch_rs2_tag = t2; dispatch_rs2_value = v2;
  endtask

  initial begin
    //                op     pc            imm           rd  r1 t1 v1            r2 t2 v2            c0v c0t c0d      c1v c1t c1d      iss exp_v1        exp_v2
    vecs[0] = '{6'h01, 32'h100,       32'h0,        3,  1, 0, 32'd5,        1, 0, 32'd7,        0, 0, 32'h0,     0, 0, 32'h0,     1, 32'd5,        32'd7};
    vecs[1] = '{6'h02, 32'h104,       32'h10,       4,  0, 9, 32'h0,        1, 0, 32'd1,        0, 0, 32'h0,     1, 9, 32'h1234,  1, 32'h1234,     32'd1};
    vecs[2] = '{6'h03, 32'h108,       32'h20,       5,  0, 6, 32'h0,        1, 0, 32'd2,        1, 6, 32'hAAAA,  1, 6, 32'hBBBB,  1, 32'hAAAA,     32'd2};
    vecs[3] = '{6'h04, 32'h10C,       32'h30,       6,  1, 6, 32'h55,       1, 0, 32'd3,        1, 6, 32'h99,    0, 0, 32'h0,     1, 32'h55,       32'd3};
    vecs[4] = '{6'h05, 32'h110,       32'h40,       7,  0, 2, 32'h0,        1, 0, 32'd4,        1, 3, 32'h77,    0, 0, 32'h0,     0, 32'h0,        32'h0};
    vecs[5] = '{6'h3F, 32'hFFFF_FFFC, 32'h8000_0000, 15, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'h0,        0, 0, 32'h0,     0, 0, 32'h0,     1, 32'hFFFF_FFFF, 32'h0};
    vecs[6] = '{6'h06, 32'h114,       32'h50,       8,  1, 0, 32'd9,        0, 1, 32'h0,        0, 0, 32'h0,     1, 1, 32'hCAFE,  1, 32'd9,        32'hCAFE};

    // Reset held with a dispatch presented: nothing may be retained.
    rst = 1'b0; rdy = 1'b1; idle();
    cdb0_tag = '0; cdb1_tag = '0; cdb0_value = '0; cdb1_value = '0;
    dispatch(6'h01, 4'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset rs_full", {31'd0, rs_full}, 32'd0);
      check("reset alu_enable", {31'd0, alu_enable}, 32'd0);
      check("reset alu_op", {26'd0, alu_op}, 32'd0);
      check("reset alu_pc", alu_pc, 32'd0);
      check("reset alu_rs1", alu_rs1_value, 32'd0);
      check("reset alu_rd", {28'd0, alu_rd_rename}, 32'd0);
    end
    rst = 1'b1; idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post-reset no issue", {31'd0, alu_enable}, 32'd0);
    end

    // Vector table: single instruction, optional same-cycle CDB bypass.
    foreach (vecs[k]) begin
      dispatch(vecs[k].op, vecs[k].rd, vecs[k].r1, vecs[k].t1, vecs[k].v1,
               vecs[k].r2, vecs[k].t2, vecs[k].v2);
      dispatch_pc  = vecs[k].pc;
      dispatch_imm = vecs[k].imm;
      cdb0_valid = vecs[k].c0v; cdb0_tag = vecs[k].c0t; cdb0_value = vecs[k].c0d;
      cdb1_valid = vecs[k].c1v; cdb1_tag = vecs[k].c1t; cdb1_value = vecs[k].c1d;
      step();
      idle();
      check($sformatf("vec%0d en cycle1", k), {31'd0, alu_enable}, 32'd0);
      step();
      check($sformatf("vec%0d en cycle2", k), {31'd0, alu_enable}, {31'd0, vecs[k].exp_issue});
      if (vecs[k].exp_issue) begin
        check($sformatf("vec%0d op", k), {26'd0, alu_op}, {26'd0, vecs[k].op});
        check($sformatf("vec%0d pc", k), alu_pc, vecs[k].pc);
        check($sformatf("vec%0d imm", k), alu_imm, vecs[k].imm);
        check($sformatf("vec%0d rs1", k), alu_rs1_value, vecs[k].exp_v1);
        check($sformatf("vec%0d rs2", k), alu_rs2_value, vecs[k].exp_v2);
        check($sformatf("vec%0d rd", k), {28'd0, alu_rd_rename}, {28'd0, vecs[k].rd});
        step();
        check($sformatf("vec%0d en cycle3", k), {31'd0, alu_enable}, 32'd0);
      end else begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
    end

    // Wakeup via cdb1 four cycles after dispatch.
    dispatch(6'h07, 4'd2, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'd11);
    step(); idle();
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("wake wait c%0d", c), {31'd0, alu_enable}, 32'd0);
      if (c < 3) step();
    end
    step();
    cdb1_valid = 1'b1; cdb1_tag = 4'd9; cdb1_value = 32'h1234;
    step(); idle();
    check("wake c5 no issue", {31'd0, alu_enable}, 32'd0);
    step();
    check("wake c6 en", {31'd0, alu_enable}, 32'd1);
    check("wake c6 rs1", alu_rs1_value, 32'h1234);
    check("wake c6 rd", {28'd0, alu_rd_rename}, 32'd2);

    // Fill: eight entries waiting on tag 5, then a dropped ninth.
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(OP_W'(i), ROB_W'(i), 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, XLEN'(i));
      step();
      check($sformatf("fill%0d rs_full", i), {31'd0, rs_full}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    dispatch(6'h2A, 4'd15, 1'b1, 4'd0, 32'hDEAD, 1'b1, 4'd0, 32'hBEEF);
    step(); idle();
    check("ninth rs_full", {31'd0, rs_full}, 32'd1);
    step();
    check("ninth not issued", {31'd0, alu_enable}, 32'd0);
    rdy = 1'b0;
    cdb0_valid = 1'b1; cdb0_tag = 4'd5; cdb0_value = 32'h77;
    step(); idle();
    check("frozen en", {31'd0, alu_enable}, 32'd0);
    check("frozen rd hold", {28'd0, alu_rd_rename}, 32'd2);
    rdy = 1'b1;
    step();
    check("frozen cdb ignored a", {31'd0, alu_enable}, 32'd0);
    step();
    check("frozen cdb ignored b", {31'd0, alu_enable}, 32'd0);
    cdb0_valid = 1'b1; cdb0_tag = 4'd5; cdb0_value = 32'h77;
    step(); idle();
    check("fill wake no issue", {31'd0, alu_enable}, 32'd0);
    check("fill still full", {31'd0, rs_full}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check($sformatf("drain%0d en", i), {31'd0, alu_enable}, 32'd1);
      check($sformatf("drain%0d rd", i), {28'd0, alu_rd_rename}, XLEN'(i));
      check($sformatf("drain%0d rs2", i), alu_rs2_value, XLEN'(i));
      check($sformatf("drain%0d rs1", i), alu_rs1_value, 32'h77);
      check($sformatf("drain%0d rs_full", i), {31'd0, rs_full}, 32'd0);
    end
    step();
    check("drain done", {31'd0, alu_enable}, 32'd0);

    // Ordering: entry 2 ready before entry 0 wakes.
    dispatch(6'h10, 4'd10, 1'b0, 4'd4, 32'h0, 1'b1, 4'd0, 32'd1);
    step();
    dispatch(6'h11, 4'd11, 1'b0, 4'd13, 32'h0, 1'b1, 4'd0, 32'd2);
    step();
    dispatch(6'h12, 4'd12, 1'b1, 4'd0, 32'h12, 1'b1, 4'd0, 32'd3);
    step(); idle();
    check("order wait", {31'd0, alu_enable}, 32'd0);
    cdb0_valid = 1'b1; cdb0_tag = 4'd4; cdb0_value = 32'h44;
    step(); idle();
    check("order first en", {31'd0, alu_enable}, 32'd1);
    check("order first rd", {28'd0, alu_rd_rename}, 32'd12);
    step();
    check("order second en", {31'd0, alu_enable}, 32'd1);
    check("order second rd", {28'd0, alu_rd_rename}, 32'd10);
    check("order second rs1", alu_rs1_value, 32'h44);
    step();
    check("order done", {31'd0, alu_enable}, 32'd0);

    // Flush with three pending entries and a concurrent ready dispatch.
    dispatch(6'h13, 4'd7, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'd4);
    step();
    dispatch(6'h14, 4'd8, 1'b0, 4'd8, 32'h0, 1'b1, 4'd0, 32'd5);
    step();
    dispatch(6'h15, 4'd14, 1'b1, 4'd0, 32'h15, 1'b1, 4'd0, 32'd6);
    flush = 1'b1;
    step(); idle();
    check("flush en", {31'd0, alu_enable}, 32'd0);
    check("flush rs_full", {31'd0, rs_full}, 32'd0);
    check("flush rd zero", {28'd0, alu_rd_rename}, 32'd0);
    cdb0_valid = 1'b1; cdb0_tag = 4'd13; cdb0_value = 32'h1;
    cdb1_valid = 1'b1; cdb1_tag = 4'd7;  cdb1_value = 32'h2;
    step();
    cdb0_tag = 4'd8; cdb1_valid = 1'b0;
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post-flush quiet%0d", i), {31'd0, alu_enable}, 32'd0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
